// File: rtl/obi_arb_pkg.sv
// Shared types for the OBI instruction/data memory arbiter: source tag,
// tracker entry layout and an elaboration-time parameter check.
package obi_arb_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

  // Lane offset is stored at a fixed width; up to 16 lanes (MEM_W <= 512).
  localparam int WOFF_W = 4;

  typedef struct packed {
    src_e              src;
    logic [WOFF_W-1:0] word_off;
  } trk_entry_t;

  function automatic bit params_ok(int mem_w, int max_out);
    int lanes;
    lanes = mem_w / 32;
    return (mem_w >= 32) && (mem_w % 32 == 0) && ((lanes & (lanes - 1)) == 0) &&
           (lanes <= (1 << WOFF_W)) && (max_out >= 2) && ((max_out & (max_out - 1)) == 0);
  endfunction

endpackage

// File: rtl/obi_src_fifo.sv
// In-order tracker FIFO of trk_entry_t; wrapping pointers plus a separate count.
module obi_src_fifo
  import obi_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  trk_entry_t               din_i,
  input  logic                     pop_i,
  output trk_entry_t               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  trk_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr] <= din_i;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Two-to-one OBI arbiter (instr/data -> mem) with in-order response steering.
// Define OBI_ARB_RR_EN for round-robin arbitration; default is fixed data priority.
module obi_mem_arbiter
  import obi_arb_pkg::*;
#(
  parameter int MEM_W           = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               instr_req_i,
  output logic                               instr_gnt_o,
  input  logic [31:0]                        instr_addr_i,
  output logic                               instr_rvalid_o,
  output logic                               instr_err_o,
  output logic [31:0]                        instr_rdata_o,
  input  logic                               data_req_i,
  output logic                               data_gnt_o,
  input  logic [31:0]                        data_addr_i,
  input  logic                               data_we_i,
  input  logic [MEM_W/8-1:0]                 data_be_i,
  input  logic [MEM_W-1:0]                   data_wdata_i,
  output logic                               data_rvalid_o,
  output logic                               data_err_o,
  output logic [MEM_W-1:0]                   data_rdata_o,
  output logic                               mem_req_o,
  input  logic                               mem_gnt_i,
  output logic [31:0]                        mem_addr_o,
  output logic                               mem_we_o,
  output logic [MEM_W/8-1:0]                 mem_be_o,
  output logic [MEM_W-1:0]                   mem_wdata_o,
  input  logic                               mem_rvalid_i,
  input  logic                               mem_err_i,
  input  logic [MEM_W-1:0]                   mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               proto_err_o
);
  localparam int LANES = MEM_W / 32;

  if (!params_ok(MEM_W, MAX_OUTSTANDING)) begin : g_param_err
    $error("obi_mem_arbiter: unsupported MEM_W / MAX_OUTSTANDING");
  end

  logic                   full, empty, accept, pop, data_wins;
  trk_entry_t             head, push_ent;
  logic [WOFF_W-1:0]      win_off;
  logic [31:0]            instr_lane;
  logic [LANES-1:0][31:0] rd_lanes;
  logic                   unused_off;

`ifdef OBI_ARB_RR_EN
  src_e last_src;

  // On a tie the port that did not win the last accepted transfer goes first.
  assign data_wins = data_req_i & (~instr_req_i | (last_src == SRC_INSTR));

  always_ff @(posedge clk_i) begin
    if (rst_i)       last_src <= SRC_DATA;
    else if (accept) last_src <= data_wins ? SRC_DATA : SRC_INSTR;
  end
`else
  assign data_wins = data_req_i;
`endif

  // Request path deliberately ignores same-cycle pops: no rvalid -> gnt path.
  assign mem_req_o   = (instr_req_i | data_req_i) & ~full;
  assign mem_addr_o  = data_wins ? data_addr_i : instr_addr_i;
  assign mem_we_o    = data_wins & data_we_i;
  assign mem_be_o    = data_wins ? data_be_i : '1;
  assign mem_wdata_o = data_wdata_i;
  assign data_gnt_o  = data_wins & mem_gnt_i & ~full;
  assign instr_gnt_o = ~data_wins & instr_req_i & mem_gnt_i & ~full;
  assign accept      = mem_req_o & mem_gnt_i;
  assign push_ent    = '{src: (data_wins ? SRC_DATA : SRC_INSTR), word_off: win_off};

  assign rd_lanes = mem_rdata_i;

  if (LANES > 1) begin : g_wide
    localparam int LB = $clog2(LANES);
    assign win_off    = WOFF_W'(mem_addr_o[LB+1:2]);
    assign instr_lane = rd_lanes[head.word_off[LB-1:0]];
  end else begin : g_narrow
    assign win_off    = '0;
    assign instr_lane = rd_lanes[0];
  end
  assign unused_off = ^head.word_off;

  obi_src_fifo #(.DEPTH(MAX_OUTSTANDING)) u_trk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .din_i   (push_ent),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

  assign pop            = mem_rvalid_i & ~empty;
  assign instr_rvalid_o = pop & (head.src == SRC_INSTR);
  assign data_rvalid_o  = pop & (head.src == SRC_DATA);
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_err_o     = data_rvalid_o & mem_err_i;
  assign instr_rdata_o  = instr_lane;
  assign data_rdata_o   = mem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i)                      proto_err_o <= 1'b0;
    else if (mem_rvalid_i && empty) proto_err_o <= 1'b1;
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Scoreboard bench for obi_mem_arbiter (MEM_W=64, depth 4): directed plan + random traffic.
module tb_obi_mem_arbiter;
  localparam int MEM_W = 64;
  localparam int MO    = 4;
  localparam int BW    = MEM_W / 8;
  localparam int CW    = $clog2(MO) + 1;
`ifdef OBI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  logic instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic data_req_i, data_gnt_o, data_we_i, data_rvalid_o, data_err_o;
  logic [31:0] data_addr_i;
  logic [BW-1:0] data_be_i, mem_be_o;
  logic [MEM_W-1:0] data_wdata_i, data_rdata_o, mem_wdata_o, mem_rdata_i;
  logic mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_addr_o;
  logic [CW-1:0] outstanding_o;
  logic proto_err_o;

  always #5 clk_i = ~clk_i;

  obi_mem_arbiter #(.MEM_W(MEM_W), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_err_o(instr_err_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
    .outstanding_o(outstanding_o), .proto_err_o(proto_err_o)
  );

  // Reference model: a queue of outstanding requests in issue order.
  typedef struct { bit is_data; int unsigned off; } ent_t;
  typedef struct { bit none; bit is_data; logic [31:0] irdata; logic [MEM_W-1:0] drdata; bit err; } rsp_t;
  ent_t mq[$];
  rsp_t exp_q[$];
  bit   m_proto = 0;
  bit   m_last_data = 1;

  int total = 0;
  int bad = 0;

  bit e_mreq, e_ignt, e_dgnt, e_we, e_proto, chk_req = 0;
  logic [31:0] e_addr;
  logic [BW-1:0] e_be;
  int e_cnt;

  function automatic void chk(string nm, logic [MEM_W-1:0] act, logic [MEM_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // Compute expected request-side values and response for the inputs just driven.
  task automatic step();
    bit full, dwin, acc;
    rsp_t r;
    ent_t e;
    full = (mq.size() == MO);
    if (data_req_i && instr_req_i) dwin = RR ? !m_last_data : 1'b1;
    else dwin = data_req_i;
    e_cnt   = mq.size();
    e_proto = m_proto;
    e_mreq  = (instr_req_i || data_req_i) && !full;
    e_dgnt  = dwin && mem_gnt_i && !full;
    e_ignt  = !dwin && instr_req_i && mem_gnt_i && !full;
    e_addr  = dwin ? data_addr_i : instr_addr_i;
    e_we    = dwin && data_we_i;
    e_be    = dwin ? data_be_i : {BW{1'b1}};
    chk_req = 1;
    acc = e_mreq && mem_gnt_i;
    if (mem_rvalid_i) begin
      r = '{none: 1, is_data: 0, irdata: '0, drdata: '0, err: mem_err_i};
      if (mq.size() == 0) m_proto = 1;
      else begin
        e = mq.pop_front();
        r.none = 0;
        r.is_data = e.is_data;
        r.irdata = 32'(mem_rdata_i >> (32 * e.off));
        r.drdata = mem_rdata_i;
      end
      exp_q.push_back(r);
    end
    if (acc) begin
      e.is_data = dwin;
      e.off = ((dwin ? data_addr_i : instr_addr_i) % BW) / 4;
      mq.push_back(e);
      m_last_data = dwin;
    end
    if (rst_i) begin
      mq.delete();
      m_proto = 0;
      m_last_data = 1;
    end
  endtask

  task automatic cyc(bit r, bit ir, logic [31:0] ia, bit dr, logic [31:0] da, bit we,
                     bit g, bit rv, logic [MEM_W-1:0] rd, bit er);
    @(posedge clk_i); #1;
    rst_i = r; instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_addr_i = da; data_we_i = we;
    data_be_i = we ? (da[11:4] | 8'h01) : {BW{1'b1}};
    data_wdata_i = {da, ~da};
    mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd; mem_err_i = er;
    step();
    #1;
  endtask

  task automatic idle(bit rv = 0);
    cyc(0, 0, 0, 0, 0, 0, 0, rv, {$urandom, $urandom}, 0);
  endtask

  // Monitor: request-side and registered checks every cycle; pops scoreboard on responses.
  always @(negedge clk_i) begin
    rsp_t r;
    if (chk_req) begin
      chk("mem_req", mem_req_o, e_mreq);
      chk("instr_gnt", instr_gnt_o, e_ignt);
      chk("data_gnt", data_gnt_o, e_dgnt);
      chk("mem_addr", mem_addr_o, e_addr);
      chk("mem_we", mem_we_o, e_we);
      chk("mem_be", mem_be_o, e_be);
      chk("mem_wdata", mem_wdata_o, data_wdata_i);
      chk("outstanding", outstanding_o, e_cnt);
      chk("proto_err", proto_err_o, e_proto);
    end
    if (mem_rvalid_i || instr_rvalid_o || data_rvalid_o) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        r = exp_q.pop_front();
        chk("instr_rvalid", instr_rvalid_o, !r.none && !r.is_data);
        chk("data_rvalid", data_rvalid_o, !r.none && r.is_data);
        chk("instr_err", instr_err_o, !r.none && !r.is_data && r.err);
        chk("data_err", data_err_o, !r.none && r.is_data && r.err);
        if (!r.none && !r.is_data) chk("instr_rdata", instr_rdata_o, r.irdata);
        if (!r.none && r.is_data) chk("data_rdata", data_rdata_o, r.drdata);
      end
    end
  end

  initial begin
    bit ip, dp, dwe, rv;
    logic [31:0] ia, da;
    rst_i = 1; instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_addr_i = 0;
    data_we_i = 0; data_be_i = '0; data_wdata_i = '0; mem_gnt_i = 0; mem_rvalid_i = 0;
    mem_err_i = 0; mem_rdata_i = '0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    chk("reset_cnt", outstanding_o, 0);
    chk("reset_proto", proto_err_o, 0);

    // Lane-aligned fetch
    cyc(0, 1, 32'h84, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 0);
    chk("fetch_lane", instr_rdata_o, 32'hAAAA_BBBB);
    chk("fetch_no_data_rvalid", data_rvalid_o, 0);

    // Simultaneous requests from reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h80, 1, 32'h1000, 0, 1, 0, 0, 0);
    chk("tie_data_gnt", data_gnt_o, !RR);
    chk("tie_instr_gnt", instr_gnt_o, RR);
    cyc(0, !RR, 32'h80, RR, 32'h1000, 0, 1, 0, 0, 0);
    chk("tie_loser_gnt", RR ? data_gnt_o : instr_gnt_o, 1);
    idle(1); idle(1);

    // Fill to full, block, then resume after one response
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'(i * 4), 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 32'h10, 0, 0, 0, 1, 0, 0, 0);
    chk("full_cnt", outstanding_o, 4);
    chk("full_req", mem_req_o, 0);
    cyc(0, 1, 32'h10, 0, 0, 0, 1, 1, {$urandom, $urandom}, 0);
    chk("full_pop_req", mem_req_o, 0);
    cyc(0, 1, 32'h10, 0, 0, 0, 1, 0, 0, 0);
    chk("resume_cnt", outstanding_o, 3);
    chk("resume_gnt", instr_gnt_o, 1);
    for (int i = 0; i < 4; i++) idle(1);

    // Push and pop in the same cycle
    cyc(0, 1, 32'h10, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h20, 0, 1, 0, 0, 0);
    cyc(0, 1, 32'h14, 0, 0, 0, 1, 1, {$urandom, $urandom}, 0);
    chk("pp_first_instr", instr_rvalid_o, 1);
    idle(1);
    chk("pp_cnt", outstanding_o, 2);
    chk("pp_second_data", data_rvalid_o, 1);
    idle(1);
    chk("pp_third_instr", instr_rvalid_o, 1);

    // Error routing
    cyc(0, 0, 0, 1, 32'h40, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, {$urandom, $urandom}, 1);
    chk("err_data", data_err_o, 1);
    chk("err_instr", instr_err_o, 0);

    // Unexpected response, sticky flag
    idle(1);
    idle();
    chk("proto_set", proto_err_o, 1);
    repeat (3) idle();
    chk("proto_sticky", proto_err_o, 1);

    // Reset with three outstanding
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'(i * 4), 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("rst_mid_cnt", outstanding_o, 0);
    chk("rst_mid_proto", proto_err_o, 0);
    idle(1);
    chk("rst_stale_instr", instr_rvalid_o, 0);
    chk("rst_stale_data", data_rvalid_o, 0);
    idle();
    chk("rst_stale_proto", proto_err_o, 1);

    // Random traffic honoring OBI hold-until-grant
    ip = 0; dp = 0; ia = 0; da = 0; dwe = 0;
    repeat (1500) begin
      if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia = $urandom & ~32'h3; end
      if (!dp && $urandom_range(0, 2) == 0) begin dp = 1; da = $urandom & ~32'h3; dwe = 1'($urandom_range(0, 1)); end
      rv = (mq.size() > 0) && ($urandom_range(0, 9) < 4);
      cyc(0, ip, ia, dp, da, dwe, $urandom_range(0, 3) != 0, rv, {$urandom, $urandom},
          $urandom_range(0, 5) == 0);
      if (e_ignt) ip = 0;
      if (e_dgnt) dp = 0;
    end
    for (int i = 0; i < MO && mq.size() > 0; i++) idle(1);
    idle();
    @(negedge clk_i); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
